me_search_window_buf: RTL and testbench

- Parametrised column-rotating search-window buffer for block-matching motion estimation.
- Holds COLS columns of COL_H pixels each:
  - COLS-1 columns form the readable search window.
  - The spare column fills from the pixel stream in parallel.
- A shift command retires the oldest window column, so the window slides one column without reloading the other columns.
- Sits between the reference-frame fetch stream and the SAD/compare datapath.

---
 rtl/me_search_window_buf.sv | 145 ++++++++++++++
 tb/tb_me_search_window_buf.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/me_search_window_buf.sv
// Column-rotating search-window buffer for block-matching motion estimation.
// COLS physical columns of COL_H pixels: COLS-1 of them form the readable
// window (logical column 0 = oldest), the spare one fills from the pixel
// stream. A shift retires the oldest window column by advancing base, so the
// window slides without reloading the remaining columns.
module me_search_window_buf #(
    parameter int DATA_W = 8,
    parameter int COL_H  = 47,
    parameter int COLS   = 4,
    parameter int ROW_W  = $clog2(COL_H),
    parameter int COL_W  = $clog2(COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_drop,
    input  logic              shift,
    output logic              shift_err,
    output logic              window_ready,
    input  logic              rd_en,
    input  logic [COL_W-1:0]  rd_col,
    input  logic [ROW_W-1:0]  rd_row,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int DEPTH  = COLS * COL_H;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(COLS + 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [COL_W-1:0]  base;
    logic [COL_W-1:0]  fill_col;
    logic [ROW_W-1:0]  wr_row;
    logic [CNT_W-1:0]  full_cols;

    logic              wr_accept;
    logic              column_done;
    logic              shift_accept;
    logic              rd_in_range;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    // Modulo-COLS increment of a column pointer (works for non-power-of-2 COLS).
    function automatic logic [COL_W-1:0] col_inc(input logic [COL_W-1:0] c);
        return (c == COL_W'(COLS - 1)) ? '0 : c + COL_W'(1);
    endfunction

    // Logical window column -> physical column, relative to the current base.
    function automatic logic [COL_W-1:0] phys_col(input logic [COL_W-1:0] b,
                                                  input logic [COL_W-1:0] c);
        int s;
        s = int'(b) + int'(c);
        if (s >= COLS) s = s - COLS;
        return COL_W'(s);
    endfunction

    // Flat storage address: physical column major, row minor.
    function automatic logic [ADDR_W-1:0] flat_addr(input logic [COL_W-1:0] c,
                                                    input logic [ROW_W-1:0] r);
        int a;
        a = int'(c) * COL_H + int'(r);
        return ADDR_W'(a);
    endfunction

    // Occupancy flags come straight from the complete-column count; the
    // buffer is full only when every physical column holds complete data.
    assign wr_ready     = full_cols < CNT_W'(COLS);
    assign window_ready = full_cols >= CNT_W'(COLS - 1);

    assign wr_accept    = wr_en && wr_ready;
    assign column_done  = wr_accept && (wr_row == ROW_W'(COL_H - 1));
    assign shift_accept = shift && window_ready;

    // Out-of-range reads still return a valid beat, but with zero data.
    assign rd_in_range  = (int'(rd_col) < COLS - 1) && (int'(rd_row) < COL_H);
    assign rd_addr      = flat_addr(phys_col(base, rd_col), rd_row);
    assign wr_addr      = flat_addr(fill_col, wr_row);

    // Pointer, occupancy and error-pulse state; flush clears it like reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base      <= '0;
            fill_col  <= '0;
            wr_row    <= '0;
            full_cols <= '0;
            wr_drop   <= 1'b0;
            shift_err <= 1'b0;
        end else if (flush) begin
            base      <= '0;
            fill_col  <= '0;
            wr_row    <= '0;
            full_cols <= '0;
            wr_drop   <= 1'b0;
            shift_err <= 1'b0;
        end else begin
            wr_drop   <= wr_en && !wr_ready;
            shift_err <= shift && !window_ready;
            if (wr_accept) begin
                if (column_done) begin
                    wr_row   <= '0;
                    fill_col <= col_inc(fill_col);
                end else begin
                    wr_row   <= wr_row + ROW_W'(1);
                end
            end
            if (shift_accept) begin
                base <= col_inc(base);
            end
            if (column_done && !shift_accept) begin
                full_cols <= full_cols + CNT_W'(1);
            end else if (!column_done && shift_accept) begin
                full_cols <= full_cols - CNT_W'(1);
            end
        end
    end

    // Registered read port: one-cycle latency, data held while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (flush) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_in_range ? mem[rd_addr] : '0;
            end
        end
    end

    // Pixel storage, not reset; a flush in the same cycle suppresses the write.
    always_ff @(posedge clk) begin
        if (wr_accept && !flush) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_me_search_window_buf.sv
// Directed bench for me_search_window_buf with COLS=4, COL_H=47, DATA_W=8.
module tb_me_search_window_buf;

    localparam int DATA_W = 8;
    localparam int COL_H  = 47;
    localparam int COLS   = 4;
    localparam int ROW_W  = 6;
    localparam int COL_W  = 2;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              wr_drop;
    logic              shift;
    logic              shift_err;
    logic              window_ready;
    logic              rd_en;
    logic [COL_W-1:0]  rd_col;
    logic [ROW_W-1:0]  rd_row;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    int checks;
    int failures;

    me_search_window_buf #(
        .DATA_W(DATA_W),
        .COL_H (COL_H),
        .COLS  (COLS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .wr_drop     (wr_drop),
        .shift       (shift),
        .shift_err   (shift_err),
        .window_ready(window_ready),
        .rd_en       (rd_en),
        .rd_col      (rd_col),
        .rd_row      (rd_row),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(first + i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic do_read(input int col, input int row);
        rd_en  = 1'b1;
        rd_col = COL_W'(col);
        rd_row = ROW_W'(row);
        tick();
        rd_en  = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        shift    = 1'b0;
        rd_en    = 1'b0;
        rd_col   = '0;
        rd_row   = '0;
        tick();
        tick();
        check("rst_wr_ready", 32'(wr_ready), 1);
        check("rst_window_ready", 32'(window_ready), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_wr_drop", 32'(wr_drop), 0);
        check("rst_shift_err", 32'(shift_err), 0);
        rst_n = 1'b1;
        tick();

        // Shift with an empty window: error pulse, base stays at 0.
        shift = 1'b1;
        tick();
        shift = 1'b0;
        check("err_shift_pulse", 32'(shift_err), 1);
        check("err_window_ready", 32'(window_ready), 0);
        tick();
        check("err_shift_clear", 32'(shift_err), 0);

        // Three columns: window becomes ready only after pixel 140.
        stream(0, 140);
        check("fill_win_before", 32'(window_ready), 0);
        stream(140, 1);
        check("fill_win_after", 32'(window_ready), 1);
        check("fill_wr_ready", 32'(wr_ready), 1);
        do_read(2, 5);
        check("fill_rd_valid", 32'(rd_valid), 1);
        check("fill_rd_data", 32'(rd_data), 99);
        tick();
        check("fill_rd_valid_off", 32'(rd_valid), 0);
        check("fill_rd_hold", 32'(rd_data), 99);

        // Spare column fills; buffer full, next pixel dropped.
        stream(141, 47);
        check("bp_wr_ready", 32'(wr_ready), 0);
        check("bp_window_ready", 32'(window_ready), 1);
        wr_en   = 1'b1;
        wr_data = 8'd188;
        tick();
        wr_en = 1'b0;
        check("bp_drop_pulse", 32'(wr_drop), 1);
        tick();
        check("bp_drop_clear", 32'(wr_drop), 0);
        do_read(0, 0);
        check("bp_rd_data", 32'(rd_data), 0);

        // Shift frees the oldest column; fill wraps to physical column 0.
        shift = 1'b1;
        tick();
        shift = 1'b0;
        check("sh_wr_ready", 32'(wr_ready), 1);
        check("sh_no_err", 32'(shift_err), 0);
        do_read(0, 0);
        check("sh_rd_col0", 32'(rd_data), 47);
        stream(188, 47);
        check("sh_full_again", 32'(wr_ready), 0);
        shift = 1'b1;
        tick();
        shift = 1'b0;
        do_read(2, 0);
        check("sh_wrap_data", 32'(rd_data), 188);

        // Spare column completes in the same cycle as an accepted shift.
        stream(235, 46);
        wr_en   = 1'b1;
        wr_data = 8'(281);
        shift   = 1'b1;
        tick();
        wr_en = 1'b0;
        shift = 1'b0;
        check("sim_window_ready", 32'(window_ready), 1);
        check("sim_wr_ready", 32'(wr_ready), 1);
        check("sim_shift_err", 32'(shift_err), 0);
        check("sim_wr_drop", 32'(wr_drop), 0);
        do_read(2, 46);
        check("sim_rd_data", 32'(rd_data), 25);

        // Out-of-range reads: valid beat with zero data.
        do_read(3, 0);
        check("oor_col_valid", 32'(rd_valid), 1);
        check("oor_col_data", 32'(rd_data), 0);
        do_read(0, 47);
        check("oor_row_valid", 32'(rd_valid), 1);
        check("oor_row_data", 32'(rd_data), 0);

        // Asynchronous reset mid-column clears outputs without a clock edge.
        stream(50, 20);
        do_read(0, 0);
        check("ar_rd_before", 32'(rd_data), 141);
        check("ar_valid_before", 32'(rd_valid), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_rd_valid", 32'(rd_valid), 0);
        check("ar_rd_data", 32'(rd_data), 0);
        check("ar_window_ready", 32'(window_ready), 0);
        check("ar_wr_ready", 32'(wr_ready), 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Flush wins over a concurrent write; write pointer restarts at row 0.
        stream(200, 3);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hAA;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        check("fl_window_ready", 32'(window_ready), 0);
        check("fl_wr_ready", 32'(wr_ready), 1);
        stream(85, 1);
        do_read(0, 0);
        check("fl_row0", 32'(rd_data), 85);
        do_read(0, 1);
        check("fl_row1", 32'(rd_data), 201);
        do_read(0, 3);
        check("fl_row3_untouched", 32'(rd_data), 191);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
